// File: rtl/seq_det_pkg.sv
// Shared types and parameter limits for the parametrised serial pattern detector.
package seq_det_pkg;

  // Detector control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // no pattern loaded, incoming bits ignored
    FILL   = 2'd1,  // history not yet deep enough to complete a match
    SEARCH = 2'd2   // every valid bit may complete a match
  } state_t;

  // Legal parameter ranges.
  localparam int PAT_W_MIN = 2;
  localparam int PAT_W_MAX = 16;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 16;

  // True when the pattern and counter widths are within the supported ranges.
  function automatic bit params_ok(input int pat_w, input int cnt_w);
    return (pat_w >= PAT_W_MIN) && (pat_w <= PAT_W_MAX) &&
           (cnt_w >= CNT_W_MIN) && (cnt_w <= CNT_W_MAX);
  endfunction

endpackage : seq_det_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with clear. Clear and increment on the same edge
// give 1: the clear is applied first, then the increment.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] w_base;
  logic [CNT_W-1:0] w_next;

  // Next count: optional clear, then saturating increment.
  always_comb begin
    w_base = clr ? '0 : count;
    w_next = w_base;
    if (inc && (w_base != CNT_MAX)) begin
      w_next = w_base + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      count <= w_next;
    end
  end

endmodule : sat_counter

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector. Matches the latest PAT_W valid bits
// against a runtime-loaded pattern (MSB = oldest bit), pulses data_out one
// cycle after the completing bit, and counts matches with saturation.
// Control handshake: a bit is consumed only on an edge with data_valid=1;
// load on the same edge wins and that bit is dropped. There is no
// back-pressure, the detector accepts one bit every cycle.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             overlap,
  input  logic             clear_cnt,
  output logic             data_out,
  output logic [CNT_W-1:0] match_count,
  output logic             armed,
  output state_t           dbg_state
);

  // Elaboration-time guard on the parameter ranges.
  if (!params_ok(PAT_W, CNT_W)) begin : g_bad_params
    $error("seq_detector_param: PAT_W or CNT_W out of range");
  end

  // Fill count only needs to reach PAT_W-1.
  localparam int                FILL_W    = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  state_t             r_state;
  logic [PAT_W-1:0]   r_pattern;
  logic [PAT_W-2:0]   r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic               r_data_out;
  logic               r_armed;

  logic [PAT_W-1:0]   w_shifted;
  logic [PAT_W-2:0]   w_hist_next;
  logic [FILL_W-1:0]  w_fill_inc;
  logic               w_bit_take;
  logic               w_match;

  // History with the current bit appended, and the match decision.
  always_comb begin
    w_shifted   = {r_hist, data_in};
    w_hist_next = w_shifted[PAT_W-2:0];
    w_fill_inc  = r_fill + FILL_W'(1);
    w_bit_take  = data_valid && !load;
    w_match     = (r_state == SEARCH) && w_bit_take && (w_shifted == r_pattern);
  end

  // Detector FSM, history, fill count, pattern register and match pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_pattern  <= '0;
      r_hist     <= '0;
      r_fill     <= '0;
      r_data_out <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_data_out <= 1'b0;
      if (load) begin
        r_pattern <= pattern_in;
        r_hist    <= '0;
        r_fill    <= '0;
        r_armed   <= 1'b1;
        r_state   <= FILL;
      end else begin
        case (r_state)
          IDLE: begin
            // Bits are ignored until a pattern is loaded.
          end
          FILL: begin
            if (data_valid) begin
              r_hist <= w_hist_next;
              r_fill <= w_fill_inc;
              if (w_fill_inc == FILL_LAST) begin
                r_state <= SEARCH;
              end
            end
          end
          SEARCH: begin
            if (data_valid) begin
              if (w_match) begin
                r_data_out <= 1'b1;
                if (overlap) begin
                  r_hist <= w_hist_next;
                end else begin
                  // Non-overlapping: the next match needs a full fresh window.
                  r_hist  <= '0;
                  r_fill  <= '0;
                  r_state <= FILL;
                end
              end else begin
                r_hist <= w_hist_next;
              end
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (w_match),
    .clr   (clear_cnt),
    .count (match_count)
  );

  assign data_out  = r_data_out;
  assign armed     = r_armed;
  assign dbg_state = r_state;

endmodule : seq_detector_param

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus a randomized run,
// checked against a queue-based reference model. Two instances share the
// stimulus: an 8-bit counter and a 2-bit counter (saturation).
module tb_seq_detector_param;
  import seq_det_pkg::*;

  localparam int PAT_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset      = 1'b0;
  logic             data_in    = 1'b0;
  logic             data_valid = 1'b0;
  logic             load       = 1'b0;
  logic [PAT_W-1:0] pattern_in = '0;
  logic             overlap    = 1'b0;
  logic             clear_cnt  = 1'b0;

  logic       dout_a, dout_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic       armed_a, armed_b;
  state_t     st_a, st_b;

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .load(load), .pattern_in(pattern_in), .overlap(overlap), .clear_cnt(clear_cnt),
    .data_out(dout_a), .match_count(cnt_a), .armed(armed_a), .dbg_state(st_a)
  );

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(2)) u_dut_b (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .load(load), .pattern_in(pattern_in), .overlap(overlap), .clear_cnt(clear_cnt),
    .data_out(dout_b), .match_count(cnt_b), .armed(armed_b), .dbg_state(st_b)
  );

  // ---------------- scoreboard / model ----------------
  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  logic             m_armed = 1'b0;
  logic [PAT_W-1:0] m_pat   = '0;
  logic             m_dout  = 1'b0;
  int               m_cnt8  = 0;
  int               m_cnt2  = 0;
  logic             m_hist[$];  // accepted bits since last clear, oldest first

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic state_t exp_state();
    if (!m_armed) return IDLE;
    if (m_hist.size() >= PAT_W - 1) return SEARCH;
    return FILL;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".dout_a"},  16'(dout_a),  16'(m_dout));
    chk({tag, ".dout_b"},  16'(dout_b),  16'(m_dout));
    chk({tag, ".cnt_a"},   16'(cnt_a),   16'(m_cnt8));
    chk({tag, ".cnt_b"},   16'(cnt_b),   16'(m_cnt2));
    chk({tag, ".armed_a"}, 16'(armed_a), 16'(m_armed));
    chk({tag, ".armed_b"}, 16'(armed_b), 16'(m_armed));
    chk({tag, ".state_a"}, 16'(st_a),    16'(exp_state()));
    chk({tag, ".state_b"}, 16'(st_b),    16'(exp_state()));
  endtask

  // ---------------- driver ----------------
  // Apply one cycle of inputs, advance the model by the same edge, check.
  task automatic cycle(input string tag, input logic v, input logic d, input logic ld,
                       input logic [PAT_W-1:0] pat, input logic ov, input logic clr);
    logic             match;
    logic [PAT_W-1:0] window;
    data_valid = v; data_in = d; load = ld; pattern_in = pat;
    overlap = ov;   clear_cnt = clr;
    match = 1'b0;
    if (ld) begin
      m_pat   = pat;
      m_armed = 1'b1;
      m_hist.delete();
    end else if (m_armed && v) begin
      m_hist.push_back(d);
      if (m_hist.size() >= PAT_W) begin
        window = '0;
        for (int i = m_hist.size() - PAT_W; i < m_hist.size(); i++)
          window = {window[PAT_W-2:0], m_hist[i]};
        match = (window == m_pat);
      end
      if (match && !ov) m_hist.delete();
      while (m_hist.size() > PAT_W - 1) void'(m_hist.pop_front());
    end
    if (clr) begin
      m_cnt8 = 0; m_cnt2 = 0;
    end
    if (match) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3)   m_cnt2++;
    end
    m_dout = match;
    @(posedge clk);
    #1;
    if (dout_a) pulses++;
    check_all(tag);
    data_valid = 1'b0; load = 1'b0; clear_cnt = 1'b0;
  endtask

  task automatic send_bits(input string tag, input logic [31:0] bits, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) cycle(tag, 1'b1, bits[i], 1'b0, '0, ov, 1'b0);
  endtask

  task automatic do_load(input logic [PAT_W-1:0] pat, input logic ov);
    cycle("load", 1'b0, 1'b0, 1'b1, pat, ov, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1: reset held, then released; bits before any load are ignored.
    repeat (3) @(posedge clk);
    #1;
    check_all("rst_hold");
    reset = 1'b1;
    for (int i = 0; i < 6; i++) cycle("preload", 1'b1, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b1, 1'b0);
    chk("preload_cnt", 16'(cnt_a), 16'd0);

    // 2: overlapping detection of 1011 in 1011011.
    do_load(4'b1011, 1'b1);
    pulses = 0;
    send_bits("ovl", 32'b1011011, 7, 1'b1);
    chk("ovl_pulses", 16'(pulses), 16'd2);
    chk("ovl_cnt",    16'(cnt_a),  16'd2);

    // 3: non-overlapping, same stream gives a single match.
    cycle("clr3", 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    do_load(4'b1011, 1'b0);
    pulses = 0;
    send_bits("novl", 32'b1011011, 7, 1'b0);
    chk("novl_pulses", 16'(pulses), 16'd1);
    chk("novl_cnt",    16'(cnt_a),  16'd1);

    // 4: invalid bit inserted mid-pattern is ignored.
    cycle("clr4", 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    do_load(4'b1011, 1'b1);
    pulses = 0;
    cycle("inv", 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    cycle("inv", 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    send_bits("inv", 32'b011, 3, 1'b1);
    chk("inv_pulses", 16'(pulses), 16'd1);
    chk("inv_cnt",    16'(cnt_a),  16'd1);

    // 5: five matches saturate the 2-bit counter; clear on a match edge gives 1.
    cycle("clr5", 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    do_load(4'b1011, 1'b1);
    send_bits("sat", 32'b1011011011011011, 16, 1'b1);
    chk("sat_cnt2", 16'(cnt_b), 16'd3);
    chk("sat_cnt8", 16'(cnt_a), 16'd5);
    send_bits("sat", 32'b01, 2, 1'b1);
    cycle("sat_clr", 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    chk("clr_match_cnt2", 16'(cnt_b), 16'd1);
    chk("clr_match_cnt8", 16'(cnt_a), 16'd1);

    // 6: asynchronous reset mid-pattern, then re-arm.
    do_load(4'b1011, 1'b1);
    send_bits("pre_rst", 32'b101, 3, 1'b1);
    #2;
    reset = 1'b0;
    m_armed = 1'b0; m_dout = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    m_hist.delete();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_low");
    reset = 1'b1;
    pulses = 0;
    cycle("post_rst", 1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_pulses", 16'(pulses), 16'd0);
    do_load(4'b1011, 1'b1);
    send_bits("rearm", 32'b1011, 4, 1'b1);
    chk("rearm_pulses", 16'(pulses), 16'd1);
    chk("rearm_cnt",    16'(cnt_a),  16'd1);

    // 7: randomized stream, occasional reload / clear / overlap changes.
    do_load(4'($urandom_range(0, 15)), 1'b1);
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            1'($urandom_range(0, 9) < 8),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 39) == 0),
            4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seq_detector_param

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector: the next generation of the single-pattern FSM detector. It samples a 1-bit serial stream and pulses `data_out` when the most recent `PAT_W` valid bits equal a runtime-loaded pattern. Overlapping or non-overlapping detection is selectable, and a saturating counter reports how many matches have occurred. It sits directly on the serial data path, with the same clock and reset as the rest of the sequential logic.

## Interface
- `PAT_W`, default 4: pattern length in bits; legal range 2..16.
- `CNT_W`, default 8: width of the match counter; legal range 1..16.
---
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `data_in`  in  1: serial data bit.
- `data_valid`  in  1: qualifies `data_in`; a bit is consumed only on an edge where this is 1.
- `load`  in  1: captures `pattern_in` and re-arms the detector.
- `pattern_in`  in  PAT_W: pattern to match; MSB is the oldest bit.
- `overlap`  in  1: 1 = overlapping detection; 0 = history cleared after each match.
- `clear_cnt`  in  1: zeroes `match_count`.
- `data_out`  out  1: one-cycle match pulse.
- `match_count`  out  CNT_W: saturating count of matches.
- `armed`  out  1: a pattern has been loaded since reset.

## Operation
- Reset values: `data_out`=0, `match_count`=0, `armed`=0; pattern register, history and fill count are 0; state is IDLE.
- **State machine** (`state_t`):
  - IDLE: no pattern loaded; bits are ignored. Exits to FILL on `load`.
  - FILL: fewer than `PAT_W-1` valid bits have been accepted since the last clear.
  - SEARCH: history holds `PAT_W-1` or more bits, so each valid bit can complete a match.
- **FILL**: each valid bit shifts into history and increments the fill count. Enter SEARCH when the fill count reaches `PAT_W-1`.
- **SEARCH**: a match occurs when `{hist[PAT_W-2:0], data_in} == pattern` on a valid edge.
  - On a match, `data_out`=1 on the following cycle.
  - With `overlap`=1, history keeps the new bit and the state stays SEARCH.
  - With `overlap`=0, history and fill count clear and the state returns to FILL.
- **`load`** (any state): pattern is captured; history, fill count and `data_out` clear; `armed`=1; state goes to FILL.
  - `load` takes priority over a simultaneous valid bit; that bit is discarded.
  - `match_count` is not affected by `load`.
- **`overlap`** is sampled on the match edge. Changing it mid-stream takes effect at the next match.
- **Counter**:
  - Increments on each match and saturates at 2^CNT_W-1.
  - `clear_cnt` zeroes it.
  - If `clear_cnt` and a match occur on the same edge, the result is 1 (clear first, then add).
- **Reset mid-operation**: reset returns the block to reset values immediately (asynchronous assert). A new `load` is required before detection resumes.

## Timing
- Latency: the bit that completes a match is sampled on edge N; `data_out`=1 during cycle N→N+1 and is never more than one cycle wide per match.
- `match_count` updates on the same edge that raises `data_out`.
- Back-to-back matches with `overlap`=1 and a periodic pattern (e.g. `11`) produce `data_out` high on consecutive cycles.
- `armed` rises on the edge after `load` is sampled.
- Reset release: the first functional edge is the first rising edge with `reset`=1.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Package `seq_det_pkg` holds:
  - the `state_t` enum (IDLE, FILL, SEARCH);
  - parameter range checks as localparams: max `PAT_W`=16, max `CNT_W`=16.
- Sub-module `sat_counter`: `CNT_W`-bit saturating counter with inputs `inc` and `clr`, and clear-then-add priority.
- The top level contains the FSM, history shift register, fill counter, pattern register and compare logic.

## Test plan
All scenarios use `PAT_W`=4, pattern `1011` and `CNT_W`=8 unless noted.
1. Hold `reset`=0, then release; drive valid bits before any `load` → `data_out`=0, `match_count`=0, `armed`=0 throughout.
2. `load` 1011, `overlap`=1, stream 1011011 (all valid) → `data_out` pulses one cycle after bit 4 and after bit 7; `match_count`=2.
3. Same stream with `overlap`=0 → a single pulse after bit 4; `match_count`=1.
4. Stream 1,0,1,1 with `data_valid`=0 on an extra inserted 0 between the first 1 and the 0 → exactly one match; the invalid bit is ignored.
5. `CNT_W`=2, drive 5 matches → `match_count`=3 (saturated); then assert `clear_cnt` on a match edge → `match_count`=1.
6. After bits 1,0,1 of the pattern, pulse `reset` low → all outputs go to 0 immediately; the next bit 1 gives no match; `load` followed by 1011 → one match.
